// File: rtl/lcd_scan_ctrl.sv
// rtl/lcd_scan_ctrl.sv - six-digit HH:MM:SS 7-segment scan driver sharing one binary-to-segment converter
// Optional leading-zero blanking of the hours tens digit: define LCD_SCAN_LZB_EN.
module lcd_scan_ctrl #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [6:0] Hrs,
    input  logic [6:0] Mins,
    input  logic [6:0] Secs,
    input  logic [6:0] AHrs,
    input  logic [6:0] AMins,
    input  logic       Show_alarm,
    output logic [6:0] Conv_bin,
    input  logic [6:0] Conv_seg1,
    input  logic [6:0] Conv_seg0,
    output logic [6:0] Seg_out,
    output logic [5:0] Dig_en,
    output logic       Frame_done
);

    typedef enum logic [2:0] {SNAP, CONV_H, CONV_M, CONV_S, HOLD} state_t;

    localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      scan_cnt;
    logic [2:0]       dig_idx;
    logic [2:0]       dig_idx_nxt;
    logic             scan_wrap;
    logic             frame_end;
    logic             commit;
    logic [6:0]       snap_h;
    logic [6:0]       snap_m;
    logic [6:0]       snap_s;
    logic             snap_alarm;
    logic [6:0]       conv_last;
    logic [5:0][6:0]  shadow;
    logic [5:0][6:0]  disp;
    logic [5:0][6:0]  disp_nxt;
    logic [13:0]      conv_pair;
    logic [13:0]      hrs_pair;
    logic [13:0]      mins_pair;
    logic [13:0]      secs_pair;

    assign scan_wrap = (scan_cnt == CNT_LAST);
    assign frame_end = scan_wrap && (dig_idx == 3'd5);
    assign commit    = (state == HOLD) && frame_end;
    assign conv_pair = {Conv_seg1, Conv_seg0};

    always_comb begin
        dig_idx_nxt = dig_idx;
        if (scan_wrap) begin
            dig_idx_nxt = (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_cnt <= 16'd0;
            dig_idx  <= 3'd0;
        end else begin
            scan_cnt <= scan_wrap ? 16'd0 : scan_cnt + 16'd1;
            dig_idx  <= dig_idx_nxt;
        end
    end

    // Commit coincides with the 5->0 wrap, so digit 0 of the new frame must see the fresh data.
    assign disp_nxt = commit ? shadow : disp;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Dig_en     <= 6'b000001;
            Seg_out    <= 7'h00;
            disp       <= '0;
            Frame_done <= 1'b0;
        end else begin
            Dig_en     <= 6'(1 << dig_idx_nxt);
            Seg_out    <= disp_nxt[dig_idx_nxt];
            disp       <= disp_nxt;
            Frame_done <= commit;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= SNAP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        Conv_bin  = conv_last;
        case (state)
            SNAP:   state_nxt = CONV_H;
            CONV_H: begin
                state_nxt = CONV_M;
                Conv_bin  = snap_h;
            end
            CONV_M: begin
                state_nxt = CONV_S;
                Conv_bin  = snap_m;
            end
            CONV_S: begin
                state_nxt = HOLD;
                Conv_bin  = snap_s;
            end
            HOLD:    state_nxt = frame_end ? SNAP : HOLD;
            default: state_nxt = SNAP;
        endcase
    end

    always_comb begin
        hrs_pair  = (snap_h > 7'd99) ? 14'd0 : conv_pair;
        mins_pair = (snap_m > 7'd99) ? 14'd0 : conv_pair;
        secs_pair = (snap_s > 7'd99 || snap_alarm) ? 14'd0 : conv_pair;
`ifdef LCD_SCAN_LZB_EN
        if (snap_h < 7'd10) begin
            hrs_pair[13:7] = 7'h00;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            snap_h     <= 7'h00;
            snap_m     <= 7'h00;
            snap_s     <= 7'h00;
            snap_alarm <= 1'b0;
            conv_last  <= 7'h00;
            shadow     <= '0;
        end else begin
            conv_last <= Conv_bin;
            case (state)
                SNAP: begin
                    if (Show_alarm) begin
                        snap_h     <= AHrs;
                        snap_m     <= AMins;
                        snap_s     <= 7'h00;
                        snap_alarm <= 1'b1;
                    end else begin
                        snap_h     <= Hrs;
                        snap_m     <= Mins;
                        snap_s     <= Secs;
                        snap_alarm <= 1'b0;
                    end
                end
                CONV_H:  shadow[5:4] <= hrs_pair;
                CONV_M:  shadow[3:2] <= mins_pair;
                CONV_S:  shadow[1:0] <= secs_pair;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// tb/tb_lcd_scan_ctrl.sv - directed table-driven bench for lcd_scan_ctrl with SCAN_DIV = 4
module tb_lcd_scan_ctrl;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [6:0] Hrs = 7'd12, Mins = 7'd34, Secs = 7'd56, AHrs = 7'd0, AMins = 7'd0;
    logic       Show_alarm = 1'b0;
    logic [6:0] Conv_bin, Conv_seg1, Conv_seg0, Seg_out;
    logic [5:0] Dig_en;
    logic       Frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    lcd_scan_ctrl #(.SCAN_DIV(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Hrs(Hrs), .Mins(Mins), .Secs(Secs),
        .AHrs(AHrs), .AMins(AMins), .Show_alarm(Show_alarm), .Conv_bin(Conv_bin),
        .Conv_seg1(Conv_seg1), .Conv_seg0(Conv_seg0), .Seg_out(Seg_out),
        .Dig_en(Dig_en), .Frame_done(Frame_done)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
            4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
            8: return 7'h7F;  default: return 7'h7B;
        endcase
    endfunction

    // External converter; values above 99 deliberately yield non-blank segments.
    assign Conv_seg1 = seg7((int'(Conv_bin) / 10) % 10);
    assign Conv_seg0 = seg7(int'(Conv_bin) % 10);

`ifdef LCD_SCAN_LZB_EN
    localparam logic [6:0] H0T = 7'h00;
`else
    localparam logic [6:0] H0T = 7'h7E;
`endif

    typedef struct {
        logic [6:0]      h, m, s, ah, am;
        logic            sa;
        logic [5:0][6:0] e;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_fd(input string nm, output int n);
        n = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clk);
            if (Frame_done) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk({nm, " frame_done timeout"}, 0, 1);
    endtask

    // Called in the Frame_done cycle; samples one full 24-cycle frame.
    task automatic scan_check(input logic [5:0][6:0] e, input string nm, input int chg);
        logic [5:0] seen;
        seen = '0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge Clk);
            for (int k = 0; k < 6; k++) begin
                if (Dig_en == 6'(1 << k) && !seen[k]) begin
                    seen[k] = 1'b1;
                    chk($sformatf("%s d%0d", nm, k), 32'(Seg_out), 32'(e[k]));
                end
            end
            if (c == chg) begin
                Hrs = 7'd13; Mins = 7'd0; Secs = 7'd0;
            end
        end
        chk({nm, " digits seen"}, 32'(seen), 32'h3F);
    endtask

    initial begin
        int n;
        logic [5:0][6:0] e;

        vecs[0] = '{h:12,  m:34,  s:56, ah:0, am:0,  sa:0,
                    e:{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F}};
        vecs[1] = '{h:12,  m:100, s:45, ah:0, am:0,  sa:0,
                    e:{7'h30, 7'h6D, 7'h00, 7'h00, 7'h33, 7'h5B}};
        vecs[2] = '{h:23,  m:45,  s:12, ah:7, am:30, sa:1,
                    e:{H0T,   7'h70, 7'h79, 7'h7E, 7'h00, 7'h00}};
        vecs[3] = '{h:0,   m:0,   s:0,  ah:0, am:0,  sa:0,
                    e:{H0T,   7'h7E, 7'h7E, 7'h7E, 7'h7E, 7'h7E}};
        vecs[4] = '{h:10,  m:9,   s:99, ah:0, am:0,  sa:0,
                    e:{7'h30, 7'h7E, 7'h7E, 7'h7B, 7'h7B, 7'h7B}};
        vecs[5] = '{h:127, m:1,   s:2,  ah:0, am:0,  sa:0,
                    e:{7'h00, 7'h00, 7'h7E, 7'h30, 7'h7E, 7'h6D}};

        repeat (3) @(negedge Clk);
        chk("reset dig_en", 32'(Dig_en), 32'h01);
        chk("reset seg_out", 32'(Seg_out), 32'h00);
        chk("reset conv_bin", 32'(Conv_bin), 32'h00);
        chk("reset frame_done", 32'(Frame_done), 32'h0);
        Reset_n = 1'b1;

        // Asynchronous reset in the middle of the scan at digit 3.
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge Clk);
            if (Dig_en == 6'b001000) begin
                n = 1;
                break;
            end
        end
        chk("reach digit 3", n, 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("async reset dig_en", 32'(Dig_en), 32'h01);
        chk("async reset seg_out", 32'(Seg_out), 32'h00);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        wait_fd("first commit", n);
        chk("first commit latency", n, 24);
        chk("first commit conv_bin", 32'(Conv_bin), 32'd56);
        scan_check(vecs[0].e, "first frame", -1);
        chk("hold conv_bin", 32'(Conv_bin), 32'd56);
        wait_fd("period", n);
        chk("frame period", n, 1);
        chk("snap conv_bin", 32'(Conv_bin), 32'd56);
        @(negedge Clk);
        chk("frame_done one cycle", 32'(Frame_done), 32'h0);
        chk("conv_h bin", 32'(Conv_bin), 32'd12);
        @(negedge Clk);
        chk("conv_m bin", 32'(Conv_bin), 32'd34);

        for (int i = 0; i < 6; i++) begin
            Hrs = vecs[i].h; Mins = vecs[i].m; Secs = vecs[i].s;
            AHrs = vecs[i].ah; AMins = vecs[i].am; Show_alarm = vecs[i].sa;
            wait_fd($sformatf("vec%0d a", i), n);
            wait_fd($sformatf("vec%0d b", i), n);
            scan_check(vecs[i].e, $sformatf("vec%0d", i), -1);
        end
        Show_alarm = 1'b0;

        // Rollover during conversion must not tear the displayed time.
        Hrs = 7'd12; Mins = 7'd59; Secs = 7'd59;
        wait_fd("roll a", n);
        wait_fd("roll b", n);
        e = {7'h30, 7'h6D, 7'h5B, 7'h7B, 7'h5B, 7'h7B};
        scan_check(e, "roll cur", 2);
        wait_fd("roll c", n);
        chk("roll period", n, 1);
        scan_check(e, "roll next", -1);
        wait_fd("roll d", n);
        e = {7'h30, 7'h79, 7'h7E, 7'h7E, 7'h7E, 7'h7E};
        scan_check(e, "roll new", -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
